cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the 8-bit processor core. It fetches 2-byte instructions over a shared 8-bit memory bus, presents the opcode to the combinational instruction decoder and samples the decoder's strobes.
- It then sequences the data access, register write-back and PC update, one instruction at a time.
- It also owns the PC, the instruction register, the run/stop control and the memory-timeout error.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- WAIT_LIMIT, 15, maximum cycles a memory request may wait for mem_ready_i before a bus error (range 1..255).

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- run_i  in  1  1 = execute; 0 = stop at the next instruction boundary.
- mem_req_o  out  1  memory request, held until accepted.
- mem_we_o  out  1  1 = write (store), 0 = read.
- mem_addr_o  out  8  memory address.
- mem_ready_i  in  1  request accepted/completed in this cycle.
- mem_rdata_i  in  8  read data, valid when mem_ready_i=1.
- pc_o  out  8  current program counter.
- ir_o  out  16  instruction register; [15:12] opcode, [7:0] immediate/jump target.
- opcode_o  out  4  equals ir_o[15:12]; feeds the decoder.
- en_jmp_i, we_mem_i, ld_mem_i, we_reg_i  in  1 each  decoder strobes, sampled only in DECODE.
- data_addr_i  in  8  LD/ST address from the register file.
- ld_data_o  out  8  byte returned by the last LD.
- reg_we_o  out  1  register-file write strobe, one cycle.
- flag_we_o  out  1  ALU flag update strobe, one cycle.
- halted_o  out  1  1 in IDLE or ERR.
- bus_err_o  out  1  sticky timeout error.
- state_o  out  3  encoded FSM state, for debug.

Behaviour:
- Reset (rst_i=1, synchronous):
  - state=IDLE, pc=RESET_PC, ir=16'h0000, ld_data_o=0, wait counter=0.
  - All strobes 0, bus_err_o=0, halted_o=1.
  - Reset overrides everything, including mid-transfer; an outstanding request is abandoned.
- State encodings: IDLE=0, FETCH_HI=1, FETCH_LO=2, DECODE=3, MEM=4, WB=5, ERR=6.
- IDLE: no request. When run_i=1, go to FETCH_HI on the next edge.
- FETCH_HI:
  - If run_i=0 on entry (first cycle, no transfer started), go to IDLE with the PC unchanged.
  - Otherwise drive mem_req_o=1, mem_we_o=0, mem_addr_o=pc.
  - On mem_ready_i: ir[15:8]<=mem_rdata_i, pc<=pc+1, go to FETCH_LO.
- FETCH_LO: same transfer. On ready: ir[7:0]<=mem_rdata_i, pc<=pc+1, go to DECODE.
- PC arithmetic is modulo 256 (8'hFF+1=8'h00). An instruction at 8'hFF takes its low byte from 8'h00.
- DECODE: exactly one cycle; decoder strobes are sampled here, with priority order:
  - en_jmp_i: pc<=ir[7:0], go to FETCH_HI.
  - we_mem_i or ld_mem_i: latch the access type, go to MEM. If both are asserted, store wins.
  - we_reg_i: go to WB.
  - None: NOP, go to FETCH_HI.
- MEM: mem_req_o=1, mem_addr_o=data_addr_i, mem_we_o=1 for a store.
  - On ready, store: go to FETCH_HI.
  - On ready, load: ld_data_o<=mem_rdata_i, go to WB.
- WB: reg_we_o=1 for one cycle. flag_we_o=1 in the same cycle iff opcode_o[3]=1 (ALU op). Go to FETCH_HI.
- Request handshake:
  - mem_req_o, mem_addr_o and mem_we_o are stable from request start until the ready cycle.
  - Ready in the first request cycle completes a zero-wait transfer.
  - mem_ready_i is ignored when mem_req_o=0.
- Timeout:
  - The wait counter clears on entry to each transfer state and increments every cycle mem_ready_i=0.
  - If WAIT_LIMIT cycles elapse without ready: bus_err_o<=1, go to ERR, drop the request.
  - Ready arriving in the WAIT_LIMIT-th cycle is accepted, not an error.
  - ERR is sticky and exits only on rst_i.
- run_i deasserted mid-instruction has no effect until the next FETCH_HI entry; the current instruction always completes.
- Throughput at zero wait states:
  - NOP or jump: 3 cycles.
  - ALU op or LDI: 4 cycles.
  - ST: 4 cycles.
  - LD: 5 cycles.

Test Plan:
- Reset with RESET_PC=8'h10, then run_i=1, zero-wait memory: first request has addr 8'h10 and 8'h11; pc_o=8'h12 in DECODE; state_o sequence 0,1,2,3.
- Memory with 3-cycle ready latency, fetch of a NOP: mem_req_o held 3 cycles per byte with a stable address; no reg_we_o; next fetch at pc+2.
- Jump instruction ir=16'hx?AB with en_jmp_i=1: next fetch address 8'hAB; no reg_we_o or mem_req in between.
- LD (ld_mem_i=1, data_addr_i=8'h40, rdata=8'h5A): read at 8'h40; ld_data_o=8'h5A; reg_we_o pulses exactly 1 cycle. ST variant: mem_we_o=1 at 8'h40, no reg_we_o.
- ALU op with opcode 4'b1010 and we_reg_i=1: reg_we_o and flag_we_o both pulse in WB. Same with LDI (opcode[3]=0): flag_we_o stays 0.
- mem_ready_i never asserted with WAIT_LIMIT=4: bus_err_o=1 after 4 request cycles, state_o=6, mem_req_o=0; run_i toggling has no effect; rst_i returns to IDLE.
- Instruction at 8'hFF: low byte read from 8'h00; run_i dropped during MEM: ST completes, then IDLE with halted_o=1.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute control for the 8-bit core.
// Owns the PC, the instruction register, run/stop and the bus timeout error.
module cpu_sequencer #(
    parameter logic [7:0]  RESET_PC   = 8'h00,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [7:0]  pc_o,
    output logic [15:0] ir_o,
    output logic [3:0]  opcode_o,
    input  logic        en_jmp_i,
    input  logic        we_mem_i,
    input  logic        ld_mem_i,
    input  logic        we_reg_i,
    input  logic [7:0]  data_addr_i,
    output logic [7:0]  ld_data_o,
    output logic        reg_we_o,
    output logic        flag_we_o,
    output logic        halted_o,
    output logic        bus_err_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_HI = 3'd1,
        FETCH_LO = 3'd2,
        DECODE   = 3'd3,
        MEM      = 3'd4,
        WB       = 3'd5,
        ERR      = 3'd6
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

    state_t      state;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [7:0]  ld_data;
    logic [7:0]  wait_cnt;
    logic        is_store;
    logic        bus_err;
    logic        xfer;
    logic        req;
    logic        timeout;

    always_comb begin
        xfer = (state == FETCH_HI) || (state == FETCH_LO) || (state == MEM);
        // A fetch that has not started yet is dropped when run_i is low
        req = xfer && !((state == FETCH_HI) && (wait_cnt == 8'd0) && !run_i);
        timeout = req && !mem_ready_i && (wait_cnt == LAST_WAIT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            ld_data  <= '0;
            wait_cnt <= '0;
            is_store <= 1'b0;
            bus_err  <= 1'b0;
        end else if (timeout) begin
            bus_err  <= 1'b1;
            state    <= ERR;
            wait_cnt <= '0;
        end else if (req && !mem_ready_i) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
            unique case (state)
                IDLE: begin
                    if (run_i) state <= FETCH_HI;
                end
                FETCH_HI: begin
                    if (!req) begin
                        state <= IDLE;
                    end else begin
                        ir[15:8] <= mem_rdata_i;
                        pc       <= pc + 8'd1;
                        state    <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    ir[7:0] <= mem_rdata_i;
                    pc      <= pc + 8'd1;
                    state   <= DECODE;
                end
                DECODE: begin
                    if (en_jmp_i) begin
                        pc    <= ir[7:0];
                        state <= FETCH_HI;
                    end else if (we_mem_i || ld_mem_i) begin
                        is_store <= we_mem_i;
                        state    <= MEM;
                    end else if (we_reg_i) begin
                        state <= WB;
                    end else begin
                        state <= FETCH_HI;
                    end
                end
                MEM: begin
                    if (is_store) begin
                        state <= FETCH_HI;
                    end else begin
                        ld_data <= mem_rdata_i;
                        state   <= WB;
                    end
                end
                WB:      state <= FETCH_HI;
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req_o  = req;
    assign mem_we_o   = (state == MEM) && is_store;
    assign mem_addr_o = (state == MEM) ? data_addr_i : pc;
    assign pc_o       = pc;
    assign ir_o       = ir;
    assign opcode_o   = ir[15:12];
    assign ld_data_o  = ld_data;
    assign reg_we_o   = (state == WB);
    assign flag_we_o  = (state == WB) && ir[15];
    assign halted_o   = (state == IDLE) || (state == ERR);
    assign bus_err_o  = bus_err;
    assign state_o    = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: vector table, multi-cycle corner sequences and a random
// program run checked against an instruction-level reference model.
module tb_cpu_sequencer;

    localparam logic [7:0] RPC = 8'h10;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        run_i = 1'b0;
    logic        mem_req_o, mem_we_o;
    logic [7:0]  mem_addr_o;
    logic        mem_ready_i = 1'b0;
    logic [7:0]  mem_rdata_i = 8'h00;
    logic [7:0]  pc_o;
    logic [15:0] ir_o;
    logic [3:0]  opcode_o;
    logic        en_jmp_i, we_mem_i, ld_mem_i, we_reg_i;
    logic [7:0]  data_addr_i;
    logic [7:0]  ld_data_o;
    logic        reg_we_o, flag_we_o, halted_o, bus_err_o;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_PC(RPC), .WAIT_LIMIT(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .run_i(run_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .pc_o(pc_o), .ir_o(ir_o), .opcode_o(opcode_o),
        .en_jmp_i(en_jmp_i), .we_mem_i(we_mem_i), .ld_mem_i(ld_mem_i),
        .we_reg_i(we_reg_i), .data_addr_i(data_addr_i),
        .ld_data_o(ld_data_o), .reg_we_o(reg_we_o), .flag_we_o(flag_we_o),
        .halted_o(halted_o), .bus_err_o(bus_err_o), .state_o(state_o)
    );

    // Bench decoder: {jmp, store, load, write-reg} per opcode
    function automatic logic [3:0] dec(input logic [3:0] op);
        if (op == 4'h1) return 4'b1000;
        if (op == 4'h2) return 4'b0010;
        if (op == 4'h3) return 4'b0100;
        if (op == 4'h4) return 4'b0001;
        if (op == 4'h5) return 4'b0110;
        if (op == 4'h6) return 4'b1001;
        if (op == 4'h9) return 4'b0010;
        if (op[3])      return 4'b0001;
        return 4'b0000;
    endfunction

    assign {en_jmp_i, we_mem_i, ld_mem_i, we_reg_i} = dec(opcode_o);
    assign data_addr_i = ir_o[7:0];

    // Memory: ready after lat request cycles (0 = never)
    logic [7:0] mem [256];
    int lat_cfg = 1;
    bit rand_lat = 1'b0;
    int wcnt = 0;
    int cur_lat = 1;

    always @(posedge clk) begin
        #2;
        mem_ready_i = 1'b0;
        mem_rdata_i = 8'($urandom);
        if (rst_i || mem_req_o !== 1'b1) begin
            wcnt = 0;
        end else begin
            wcnt++;
            if (wcnt == 1) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat_cfg;
            if (wcnt == cur_lat) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = mem[mem_addr_o];
                wcnt = 0;
            end
        end
    end

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] addr;
        logic [7:0] data;
        logic       flag;
    } ev_t;

    function automatic ev_t mk(logic [1:0] k, logic [7:0] a, logic [7:0] d, logic f);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.flag = f;
        return e;
    endfunction

    ev_t log_q[$];
    ev_t exp_q[$];
    logic [7:0] exp_pc;
    int rd_cnt, wr_cnt, reg_cnt, flag_cnt, busy_cnt;
    int checks = 0;
    int errors = 0;
    logic prev_req = 1'b0, prev_rdy = 1'b0, prev_we = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic observe();
        if (rst_i) begin
            prev_req = 1'b0;
        end else begin
            if (mem_req_o === 1'b1 && prev_req && !prev_rdy) begin
                checks++;
                if (mem_addr_o !== prev_addr || mem_we_o !== prev_we) begin
                    errors++;
                    $display("FAIL hold addr %0h we %0b was %0h %0b",
                             mem_addr_o, mem_we_o, prev_addr, prev_we);
                end
            end
            prev_req  = (mem_req_o === 1'b1);
            prev_rdy  = mem_ready_i;
            prev_addr = mem_addr_o;
            prev_we   = mem_we_o;
            if (mem_req_o === 1'b1 && mem_ready_i) begin
                if (mem_we_o) begin
                    wr_cnt++;
                    log_q.push_back(mk(2'd1, mem_addr_o, 8'h00, 1'b0));
                end else begin
                    rd_cnt++;
                    log_q.push_back(mk(2'd0, mem_addr_o, mem_rdata_i, 1'b0));
                end
            end
            if (reg_we_o === 1'b1) begin
                reg_cnt++;
                log_q.push_back(mk(2'd2, 8'h00, ld_data_o, flag_we_o));
            end
            if (flag_we_o === 1'b1) flag_cnt++;
            if (halted_o === 1'b0) busy_cnt++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        log_q.delete();
        rd_cnt = 0;
        wr_cnt = 0;
        reg_cnt = 0;
        flag_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        run_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int limit);
        for (int n = 0; n < limit && halted_o !== 1'b1; n++) tick();
        chk({name, " halt"}, 32'(halted_o), 1);
    endtask

    // Instruction-level model: replays the program until it has as many events
    task automatic run_model(input int n_ev);
        logic [7:0] pc, hi, lo, ld;
        logic [3:0] d;
        exp_q.delete();
        pc = RPC;
        ld = 8'h00;
        while (exp_q.size() < n_ev) begin
            hi = mem[pc];
            exp_q.push_back(mk(2'd0, pc, hi, 1'b0));
            pc = pc + 8'd1;
            lo = mem[pc];
            exp_q.push_back(mk(2'd0, pc, lo, 1'b0));
            pc = pc + 8'd1;
            d = dec(hi[7:4]);
            if (d[3]) begin
                pc = lo;
            end else if (d[2]) begin
                exp_q.push_back(mk(2'd1, lo, 8'h00, 1'b0));
            end else if (d[1]) begin
                ld = mem[lo];
                exp_q.push_back(mk(2'd0, lo, ld, 1'b0));
                exp_q.push_back(mk(2'd2, 8'h00, ld, hi[7]));
            end else if (d[0]) begin
                exp_q.push_back(mk(2'd2, 8'h00, ld, hi[7]));
            end
        end
        exp_pc = pc;
    endtask

    typedef struct {
        logic [15:0] instr;
        int          lat;
        int          cyc;
        logic [7:0]  pc;
        int          rds;
        int          wrs;
        int          regs;
        int          flags;
        logic [7:0]  ld;
    } vec_t;

    vec_t vt [12];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // cyc counts the one extra FETCH_HI cycle that sees run_i=0
        vt[0]  = '{16'h0040, 1,  4, 8'h12, 2, 0, 0, 0, 8'h00};
        vt[1]  = '{16'h0040, 3,  8, 8'h12, 2, 0, 0, 0, 8'h00};
        vt[2]  = '{16'h10AB, 1,  4, 8'hAB, 2, 0, 0, 0, 8'h00};
        vt[3]  = '{16'h2040, 1,  6, 8'h12, 3, 0, 1, 0, 8'h5A};
        vt[4]  = '{16'h3040, 1,  5, 8'h12, 2, 1, 0, 0, 8'h00};
        vt[5]  = '{16'hA040, 1,  5, 8'h12, 2, 0, 1, 1, 8'h00};
        vt[6]  = '{16'h4040, 1,  5, 8'h12, 2, 0, 1, 0, 8'h00};
        vt[7]  = '{16'h5040, 1,  5, 8'h12, 2, 1, 0, 0, 8'h00};
        vt[8]  = '{16'h60CD, 2,  6, 8'hCD, 2, 0, 0, 0, 8'h00};
        vt[9]  = '{16'h9040, 4, 15, 8'h12, 3, 0, 1, 1, 8'h5A};
        vt[10] = '{16'hF040, 4, 11, 8'h12, 2, 0, 1, 1, 8'h00};
        vt[11] = '{16'h3040, 3, 11, 8'h12, 2, 1, 0, 0, 8'h00};

        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        // Reset values and first zero-wait fetch
        do_reset();
        chk("rst state", 32'(state_o), 0);
        chk("rst pc", 32'(pc_o), 32'(RPC));
        chk("rst ir", 32'(ir_o), 0);
        chk("rst ld", 32'(ld_data_o), 0);
        chk("rst halted", 32'(halted_o), 1);
        chk("rst err", 32'(bus_err_o), 0);
        chk("rst req", 32'(mem_req_o), 0);
        chk("rst regwe", 32'(reg_we_o), 0);
        chk("rst flagwe", 32'(flag_we_o), 0);
        lat_cfg = 1;
        rand_lat = 1'b0;
        clear_obs();
        run_i = 1'b1;
        tick();
        chk("seq state1", 32'(state_o), 1);
        chk("seq addr hi", 32'(mem_addr_o), 32'h10);
        chk("seq req hi", 32'(mem_req_o), 1);
        chk("seq we hi", 32'(mem_we_o), 0);
        tick();
        chk("seq state2", 32'(state_o), 2);
        chk("seq addr lo", 32'(mem_addr_o), 32'h11);
        tick();
        chk("seq state3", 32'(state_o), 3);
        chk("seq pc decode", 32'(pc_o), 32'h12);
        run_i = 1'b0;
        wait_halt("seq", 20);

        // Single-instruction vectors
        for (int i = 0; i < 12; i++) begin
            do_reset();
            mem[8'h10] = vt[i].instr[15:8];
            mem[8'h11] = vt[i].instr[7:0];
            mem[8'h40] = 8'h5A;
            lat_cfg = vt[i].lat;
            rand_lat = 1'b0;
            clear_obs();
            run_i = 1'b1;
            tick();
            tick();
            run_i = 1'b0;
            wait_halt($sformatf("v%0d", i), 60);
            chk($sformatf("v%0d cycles", i), busy_cnt, vt[i].cyc);
            chk($sformatf("v%0d pc", i), 32'(pc_o), 32'(vt[i].pc));
            chk($sformatf("v%0d reads", i), rd_cnt, vt[i].rds);
            chk($sformatf("v%0d writes", i), wr_cnt, vt[i].wrs);
            chk($sformatf("v%0d regwe", i), reg_cnt, vt[i].regs);
            chk($sformatf("v%0d flagwe", i), flag_cnt, vt[i].flags);
            chk($sformatf("v%0d lddata", i), 32'(ld_data_o), 32'(vt[i].ld));
            chk($sformatf("v%0d err", i), 32'(bus_err_o), 0);
        end

        // Reset abandons a transfer, then a never-ready bus times out
        do_reset();
        lat_cfg = 0;
        run_i = 1'b1;
        tick();
        tick();
        chk("abort req", 32'(mem_req_o), 1);
        rst_i = 1'b1;
        tick();
        chk("abort state", 32'(state_o), 0);
        chk("abort req off", 32'(mem_req_o), 0);
        chk("abort pc", 32'(pc_o), 32'(RPC));
        rst_i = 1'b0;
        tick();
        begin
            int n;
            n = 0;
            for (int k = 0; k < 20 && bus_err_o !== 1'b1; k++) begin
                if (mem_req_o === 1'b1) n++;
                tick();
            end
            chk("tmo err", 32'(bus_err_o), 1);
            chk("tmo req cycles", n, 4);
        end
        chk("tmo state", 32'(state_o), 6);
        chk("tmo req", 32'(mem_req_o), 0);
        chk("tmo halted", 32'(halted_o), 1);
        repeat (3) begin
            run_i = 1'b0;
            tick();
            run_i = 1'b1;
            tick();
        end
        chk("tmo sticky state", 32'(state_o), 6);
        chk("tmo sticky err", 32'(bus_err_o), 1);
        do_reset();
        chk("tmo rst state", 32'(state_o), 0);
        chk("tmo rst err", 32'(bus_err_o), 0);

        // PC wrap at 8'hFF plus run_i dropped during a store
        mem[8'h10] = 8'h10;
        mem[8'h11] = 8'hFF;
        mem[8'hFF] = 8'h30;
        mem[8'h00] = 8'h40;
        lat_cfg = 1;
        clear_obs();
        run_i = 1'b1;
        for (int k = 0; k < 40 && state_o !== 3'd4; k++) tick();
        chk("wrap in mem", 32'(state_o), 4);
        run_i = 1'b0;
        wait_halt("wrap", 20);
        chk("wrap events", log_q.size(), 5);
        if (log_q.size() == 5) begin
            chk("wrap rd ff", 32'(log_q[2].addr), 32'hFF);
            chk("wrap rd 00", 32'(log_q[3].addr), 32'h00);
            chk("wrap st kind", 32'(log_q[4].kind), 1);
            chk("wrap st addr", 32'(log_q[4].addr), 32'h40);
        end
        chk("wrap pc", 32'(pc_o), 32'h01);
        chk("wrap state", 32'(state_o), 0);
        chk("wrap regwe", reg_cnt, 0);

        // Random programs with random wait states against the model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
            rand_lat = 1'b1;
            clear_obs();
            run_i = 1'b1;
            repeat (300) tick();
            run_i = 1'b0;
            wait_halt($sformatf("rand%0d", r), 60);
            run_model(log_q.size());
            chk($sformatf("rand%0d count", r), log_q.size(), exp_q.size());
            for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d ev%0d got %0h expected %0h",
                             r, i, log_q[i], exp_q[i]);
                    break;
                end
            end
            chk($sformatf("rand%0d pc", r), 32'(pc_o), 32'(exp_pc));
            chk($sformatf("rand%0d err", r), 32'(bus_err_o), 0);
        end
        rand_lat = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
